// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-memory DMA controller. A CPU write to 16'h4014 halts the CPU and
// copies 256 bytes from page {data,8'h00} to the OAM data port at 16'h2004,
// one read and one write per byte, in ascending source order. While idle the
// shared bus is a combinational pass-through of the CPU bus.
//
// Build option:
//   OAM_DMA_ALIGN_EN  when defined, an extra ALIGN cycle is inserted after HALT
//                     if the DMA started on an odd CPU cycle (514-cycle stall
//                     instead of 513). When undefined, ALIGN and the cycle
//                     parity flop are not built and the stall is always 513.
//
// Ports:
//   clk         in   system clock, one edge per CPU cycle
//   reset       in   synchronous, active-high reset
//   cpu_addr    in   CPU address (ignored outside IDLE)
//   cpu_dout    in   CPU write data (ignored outside IDLE)
//   cpu_we      in   CPU write strobe (ignored outside IDLE)
//   cpu_rdy     out  CPU ready, 0 = CPU halted
//   bus_addr    out  shared bus address
//   bus_dout    out  shared bus write data
//   bus_we      out  shared bus write strobe
//   bus_din     in   shared bus read data
//   dma_active  out  1 while the DMA owns the bus
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus passes through from the CPU; watching for a 4014 write
// HALT  | one dead cycle while the CPU stalls; bus shows cpu_addr
// ALIGN | optional dead cycle to realign to an even CPU cycle
// READ  | bus reads {page,idx}; read data captured into data_q
// WRITE | bus writes data_q to 2004; advances idx or finishes
// -----------------------------------------------------------------------------
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  localparam logic [15:0] TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_ADDR  = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
`ifdef OAM_DMA_ALIGN_EN
    ALIGN,
`endif
    READ,
    WRITE
  } state_t;

  state_t     r_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_data_q;
  logic       r_cpu_rdy;
  logic       r_dma_active;
`ifdef OAM_DMA_ALIGN_EN
  logic       r_cyc_odd;
`endif

  logic w_trigger;

  assign w_trigger = (r_state == IDLE) && cpu_we && (cpu_addr == TRIG_ADDR);

  // Reset wins over a trigger sampled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_data_q     <= 8'h00;
      r_cpu_rdy    <= 1'b1;
      r_dma_active <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      r_cyc_odd    <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_ALIGN_EN
      r_cyc_odd <= ~r_cyc_odd;
`endif
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page       <= cpu_dout;
            r_idx        <= 8'h00;
            r_state      <= HALT;
            r_cpu_rdy    <= 1'b0;
            r_dma_active <= 1'b1;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (r_cyc_odd) r_state <= ALIGN;
          else           r_state <= READ;
`else
          r_state <= READ;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: r_state <= READ;
`endif
        READ: begin
          r_data_q <= bus_din;
          r_state  <= WRITE;
        end
        WRITE: begin
          // idx wraps within the page; the page byte is never incremented.
          if (r_idx == 8'hFF) begin
            r_state      <= IDLE;
            r_cpu_rdy    <= 1'b1;
            r_dma_active <= 1'b0;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= READ;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_cpu_rdy    <= 1'b1;
          r_dma_active <= 1'b0;
        end
      endcase
    end
  end

  // Bus mux: pass-through in IDLE, otherwise owned by the DMA. HALT/ALIGN
  // keep the CPU address on the bus but never write.
  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_we   = 1'b0;
    case (r_state)
      IDLE:  bus_we = cpu_we;
      READ:  bus_addr = {r_page, r_idx};
      WRITE: begin
        bus_addr = OAM_ADDR;
        bus_dout = r_data_q;
        bus_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_rdy    = r_cpu_rdy;
  assign dma_active = r_dma_active;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic        dma_active;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_ON = 1;
`else
  localparam int ALIGN_ON = 0;
`endif

  oam_dma_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_we     (bus_we),
    .bus_din    (bus_din),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Shared memory seen by the DMA read port.
  logic [7:0] mem [0:65535];
  assign bus_din = mem[bus_addr];

  // Expected CPU-cycle parity: cleared by reset, toggles every other edge.
  logic tb_par;
  always @(posedge clk) begin
    if (reset) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  int nvec = 0;
  int nerr = 0;

  // Per-transfer observations gathered by run_dma.
  logic [7:0] wr_q [$];
  int         wr_cyc [$];
  int         stall, n_idle_like, n_bad_rd, n_bad_wr;
  bit         trig_ok, halt_par, timed_out;
  logic       last_rdy, last_act, last_we;
  logic [15:0] last_addr, last_cpu_addr;

  task automatic drive_idle();
    cpu_addr = 16'h1234;
    cpu_dout = 8'h00;
    cpu_we   = 1'b0;
  endtask

  // Called just after a negedge; delays one cycle if needed so that the
  // HALT cycle following the trigger has the requested parity.
  task automatic set_halt_parity(input bit want);
    if (tb_par == want) @(negedge clk);
  endtask

  // Issues a trigger in the current cycle and follows the transfer until
  // cpu_rdy returns. abort_after > 0 asserts reset for one cycle, one cycle
  // after that many 2004 writes have been seen.
  task automatic run_dma(input logic [7:0] page, input bit disturb, input int abort_after);
    int cyc;
    int abort_cyc;
    bit done;
    wr_q.delete();
    wr_cyc.delete();
    stall = 0; n_idle_like = 0; n_bad_rd = 0; n_bad_wr = 0; timed_out = 0;
    abort_cyc = -1;
    cpu_addr = 16'h4014; cpu_dout = page; cpu_we = 1'b1;
    #1;
    trig_ok = (cpu_rdy === 1'b1) && (dma_active === 1'b0) && (bus_we === 1'b1) &&
              (bus_addr === 16'h4014) && (bus_dout === page);
    halt_par = ~tb_par;
    cyc = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cpu_rdy === 1'b1) begin
        done = 1;
        last_rdy = cpu_rdy; last_act = dma_active; last_we = bus_we;
        last_addr = bus_addr; last_cpu_addr = cpu_addr;
      end else begin
        stall++;
        if (bus_we === 1'b1 && bus_addr === 16'h2004) begin
          wr_q.push_back(bus_dout);
          wr_cyc.push_back(cyc);
          if (wr_q.size() == abort_after) abort_cyc = cyc + 1;
        end else if (bus_we === 1'b1) n_bad_wr++;
        else if (bus_addr === cpu_addr) n_idle_like++;
        else if (bus_addr[15:8] !== page) n_bad_rd++;
        if (cyc >= 700) begin timed_out = 1; done = 1; end
      end
      reset = (cyc == abort_cyc);
      if (disturb && cyc == 9) begin
        cpu_addr = 16'h4014; cpu_dout = 8'h03; cpu_we = 1'b1;
      end else if (disturb && cyc == 10) begin
        cpu_addr = 16'h4015; cpu_dout = 8'h77; cpu_we = 1'b1;
      end else if (disturb && cyc == 11) begin
        cpu_addr = 16'h4014; cpu_dout = 8'h00; cpu_we = 1'b0;
      end else drive_idle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    nvec++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      nerr++; $display("FAIL reset.status rdy=%b act=%b exp rdy=1 act=0", cpu_rdy, dma_active);
    end
    // Trigger presented together with reset must be ignored.
    cpu_addr = 16'h4014; cpu_dout = 8'h02; cpu_we = 1'b1;
    #1;
    nvec++; if (bus_addr !== 16'h4014 || bus_we !== 1'b1 || bus_dout !== 8'h02) begin
      nerr++; $display("FAIL reset.passthru addr=%h we=%b dout=%h exp 4014/1/02", bus_addr, bus_we, bus_dout);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    nvec++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      nerr++; $display("FAIL reset.trig_ignored rdy=%b act=%b exp rdy=1 act=0", cpu_rdy, dma_active);
    end
    nvec++; if (bus_addr !== 16'h1234 || bus_we !== 1'b0) begin
      nerr++; $display("FAIL reset.idle_bus addr=%h we=%b exp 1234/0", bus_addr, bus_we);
    end
    @(negedge clk);
    nvec++; if (cpu_rdy !== 1'b1) begin
      nerr++; $display("FAIL reset.still_idle rdy=%b exp 1", cpu_rdy);
    end
  endtask

  task automatic test_basic();
    int nb;
    set_halt_parity(1'b0);
    run_dma(8'h02, 1'b0, 0);
    nvec++; if (!trig_ok) begin nerr++; $display("FAIL basic.trigger_cycle ok=%0d exp 1", trig_ok); end
    nvec++; if (timed_out) begin nerr++; $display("FAIL basic.timeout got stall %0d exp 513", stall); end
    nvec++; if (stall !== 513) begin nerr++; $display("FAIL basic.stall got %0d exp 513", stall); end
    nvec++; if (wr_q.size() !== 256) begin nerr++; $display("FAIL basic.writes got %0d exp 256", wr_q.size()); end
    nb = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] exp_d, got_d;
      exp_d = 8'(i) ^ 8'h5A;
      got_d = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
      nvec++; if (got_d !== exp_d) begin
        nerr++; nb++;
        if (nb < 8) $display("FAIL basic.data[%0d] got %h exp %h", i, got_d, exp_d);
      end
    end
    nvec++; if (wr_cyc.size() == 0 || wr_cyc[wr_cyc.size()-1] !== 513) begin
      nerr++; $display("FAIL basic.last_write_cycle got %0d exp 513", (wr_cyc.size() == 0) ? -1 : wr_cyc[wr_cyc.size()-1]);
    end
    nvec++; if (n_idle_like !== 1) begin nerr++; $display("FAIL basic.halt_cycles got %0d exp 1", n_idle_like); end
    nvec++; if (n_bad_rd !== 0 || n_bad_wr !== 0) begin
      nerr++; $display("FAIL basic.stray_access rd=%0d wr=%0d exp 0/0", n_bad_rd, n_bad_wr);
    end
  endtask

  task automatic test_align();
    int exp_stall, nb;
    set_halt_parity(1'b1);
    exp_stall = 513 + ALIGN_ON;
    run_dma(8'h02, 1'b0, 0);
    nvec++; if (timed_out || stall !== exp_stall) begin
      nerr++; $display("FAIL align.stall got %0d exp %0d", stall, exp_stall);
    end
    nvec++; if (n_idle_like !== 1 + ALIGN_ON) begin
      nerr++; $display("FAIL align.dead_cycles got %0d exp %0d", n_idle_like, 1 + ALIGN_ON);
    end
    nvec++; if (wr_q.size() !== 256) begin nerr++; $display("FAIL align.writes got %0d exp 256", wr_q.size()); end
    nb = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++)
      if (wr_q[i] !== (8'(i) ^ 8'h5A)) nb++;
    nvec++; if (nb !== 0) begin nerr++; $display("FAIL align.data bad_bytes %0d exp 0", nb); end
    nvec++; if (wr_cyc.size() == 0 || wr_cyc[wr_cyc.size()-1] !== exp_stall) begin
      nerr++; $display("FAIL align.last_write_cycle got %0d exp %0d", (wr_cyc.size() == 0) ? -1 : wr_cyc[wr_cyc.size()-1], exp_stall);
    end
  endtask

  task automatic test_page_ff();
    int nb;
    set_halt_parity(1'b0);
    run_dma(8'hFF, 1'b0, 0);
    nvec++; if (timed_out || stall !== 513) begin nerr++; $display("FAIL pageff.stall got %0d exp 513", stall); end
    nvec++; if (n_bad_rd !== 0) begin nerr++; $display("FAIL pageff.reads_outside_page got %0d exp 0", n_bad_rd); end
    nvec++; if (wr_q.size() !== 256) begin nerr++; $display("FAIL pageff.writes got %0d exp 256", wr_q.size()); end
    nb = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++)
      if (wr_q[i] !== (8'(i) ^ 8'h3C)) nb++;
    nvec++; if (nb !== 0) begin nerr++; $display("FAIL pageff.data bad_bytes %0d exp 0", nb); end
    nvec++; if (wr_cyc.size() == 0 || wr_cyc[wr_cyc.size()-1] !== 513) begin
      nerr++; $display("FAIL pageff.last_write_cycle got %0d exp 513", (wr_cyc.size() == 0) ? -1 : wr_cyc[wr_cyc.size()-1]);
    end
  endtask

  task automatic test_reset_abort();
    int extra_wr, extra_busy;
    set_halt_parity(1'b0);
    run_dma(8'h02, 1'b0, 100);
    nvec++; if (timed_out) begin nerr++; $display("FAIL abort.timeout stall %0d exp abort", stall); end
    nvec++; if (wr_q.size() !== 100) begin nerr++; $display("FAIL abort.writes_before got %0d exp 100", wr_q.size()); end
    nvec++; if (last_rdy !== 1'b1 || last_act !== 1'b0) begin
      nerr++; $display("FAIL abort.status rdy=%b act=%b exp rdy=1 act=0", last_rdy, last_act);
    end
    nvec++; if (last_addr !== last_cpu_addr || last_we !== 1'b0) begin
      nerr++; $display("FAIL abort.passthru addr=%h we=%b exp %h/0", last_addr, last_we, last_cpu_addr);
    end
    extra_wr = 0; extra_busy = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus_we === 1'b1 && bus_addr === 16'h2004) extra_wr++;
      if (cpu_rdy !== 1'b1) extra_busy++;
    end
    nvec++; if (extra_wr !== 0 || extra_busy !== 0) begin
      nerr++; $display("FAIL abort.after wr=%0d busy=%0d exp 0/0", extra_wr, extra_busy);
    end
  endtask

  task automatic test_ignore();
    int nb, busy;
    logic [15:0] a;
    logic w;
    set_halt_parity(1'b0);
    run_dma(8'h02, 1'b1, 0);
    nvec++; if (timed_out || stall !== 513) begin nerr++; $display("FAIL ignore.stall got %0d exp 513", stall); end
    nb = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++)
      if (wr_q[i] !== (8'(i) ^ 8'h5A)) nb++;
    nvec++; if (wr_q.size() !== 256 || nb !== 0) begin
      nerr++; $display("FAIL ignore.page_kept writes=%0d bad_bytes=%0d exp 256/0", wr_q.size(), nb);
    end
    busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) busy++;
    end
    nvec++; if (busy !== 0) begin nerr++; $display("FAIL ignore.no_retrigger busy_cycles %0d exp 0", busy); end
    // IDLE accesses that are not triggers: read 4014, write 4015, write 4013.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin a = 16'h4014; w = 1'b0; end
        1:       begin a = 16'h4015; w = 1'b1; end
        default: begin a = 16'h4013; w = 1'b1; end
      endcase
      cpu_addr = a; cpu_we = w; cpu_dout = 8'h05;
      #1;
      nvec++; if (bus_addr !== a || bus_we !== w || bus_dout !== 8'h05) begin
        nerr++; $display("FAIL ignore.passthru[%0d] addr=%h we=%b dout=%h exp %h/%b/05", k, bus_addr, bus_we, bus_dout, a, w);
      end
      @(negedge clk);
      nvec++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
        nerr++; $display("FAIL ignore.no_start[%0d] rdy=%b act=%b exp 1/0", k, cpu_rdy, dma_active);
      end
      drive_idle();
    end
  endtask

  task automatic test_back_to_back();
    int exp1, exp2, nb;
    run_dma(8'h02, 1'b0, 0);
    exp1 = 513 + ALIGN_ON * int'(halt_par);
    nvec++; if (timed_out || stall !== exp1 || wr_q.size() !== 256) begin
      nerr++; $display("FAIL b2b.first stall=%0d writes=%0d exp %0d/256", stall, wr_q.size(), exp1);
    end
    run_dma(8'hFF, 1'b0, 0);
    exp2 = 513 + ALIGN_ON * int'(halt_par);
    nvec++; if (!trig_ok) begin nerr++; $display("FAIL b2b.idle_gap trigger_ok=%0d exp 1", trig_ok); end
    nvec++; if (timed_out || stall !== exp2) begin nerr++; $display("FAIL b2b.second_stall got %0d exp %0d", stall, exp2); end
    nb = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++)
      if (wr_q[i] !== (8'(i) ^ 8'h3C)) nb++;
    nvec++; if (wr_q.size() !== 256 || nb !== 0) begin
      nerr++; $display("FAIL b2b.second_data writes=%0d bad_bytes=%0d exp 256/0", wr_q.size(), nb);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = 8'(i) ^ 8'h99;
      mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
    end
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_basic();
    test_align();
    test_page_ff();
    test_reset_abort();
    test_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
